// File: rtl/icache_line_fetcher_pkg.sv
// rtl/icache_line_fetcher_pkg.sv - shared state encodings and line geometry for the line fetcher
// Critical-word-first issue order is enabled by defining ICACHE_CRIT_WORD_FIRST_EN.
package icache_line_fetcher_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_DRAIN = 2'b10,
      ST_RESP  = 2'b11
   } fetch_state_t;

   localparam int WORD_BITS  = 32;
   localparam int LINE_WORDS = 8;
   localparam int LINE_BITS  = 256;
   localparam int OFFSET_W   = 3;

endpackage

// File: rtl/icache_line_buffer.sv
// rtl/icache_line_buffer.sv - 256-bit line register written one 32-bit slot at a time
// Holds its contents between lines so the cache can sample after the valid pulse.
module icache_line_buffer
   import icache_line_fetcher_pkg::*;
(
   input  logic                    cpu_clk,
   input  logic                    cpu_rst_n,
   input  logic                    wr_en,
   input  logic [OFFSET_W-1:0]     wr_slot,
   input  logic [WORD_BITS-1:0]    wr_data,
   output logic [LINE_BITS-1:0]    line
);

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         line <= '0;
      end else if (wr_en) begin
         line[wr_slot*WORD_BITS +: WORD_BITS] <= wr_data;
      end
   end

endmodule

// File: rtl/icache_line_fetcher.sv
// rtl/icache_line_fetcher.sv - turns one line refill into 8 word reads of the instruction RAM
// Define ICACHE_CRIT_WORD_FIRST_EN to start issuing at the requested word and wrap within the line.
module icache_line_fetcher
   import icache_line_fetcher_pkg::*;
#(
   parameter int ADDR_W     = 15,
   parameter int LINE_WORDS = 8
)(
   input  logic                 cpu_clk,
   input  logic                 cpu_rst_n,
   output logic                 dev_rrdy,
   input  logic [3:0]           cpu_ren,
   input  logic [31:0]          cpu_raddr,
   output logic                 dev_rvalid,
   output logic [LINE_BITS-1:0] dev_rdata,
   output logic                 mem_en,
   output logic [31:0]          mem_addr,
   input  logic [31:0]          mem_rdata
);

   fetch_state_t        state, state_nxt;
   logic [ADDR_W-6:0]   base_q;
   logic [OFFSET_W-1:0] start_q;
   logic [OFFSET_W-1:0] issue_cnt;
   logic [OFFSET_W-1:0] ret_cnt;
   logic [OFFSET_W-1:0] issue_word;
   logic                accept;
   logic                cap_en;
   logic                unused_raddr;

   assign unused_raddr = ^{cpu_raddr[31:ADDR_W], cpu_raddr[4:0]};

   assign accept     = (state == ST_IDLE) && (cpu_ren != 4'd0);
   // Offset arithmetic is 3 bits wide, so the word index wraps inside the line.
   assign issue_word = start_q + issue_cnt;
   // RAM latency is one cycle: captures trail issues by one, the last landing in DRAIN.
   assign cap_en     = ((state == ST_ISSUE) && (issue_cnt != 3'd0)) || (state == ST_DRAIN);

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      dev_rrdy   = 1'b0;
      dev_rvalid = 1'b0;
      mem_en     = 1'b0;
      mem_addr   = 32'd0;
      case (state)
         ST_IDLE: begin
            dev_rrdy = 1'b1;
            if (accept) state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            mem_en   = 1'b1;
            mem_addr = {{(32-ADDR_W){1'b0}}, base_q, issue_word, 2'b00};
            if (issue_cnt == 3'd7) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            dev_rvalid = 1'b1;
            state_nxt  = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         base_q    <= '0;
         start_q   <= '0;
         issue_cnt <= '0;
         ret_cnt   <= '0;
      end else begin
         if (accept) begin
            base_q    <= cpu_raddr[ADDR_W-1:5];
`ifdef ICACHE_CRIT_WORD_FIRST_EN
            start_q   <= cpu_raddr[4:2];
`else
            start_q   <= 3'd0;
`endif
            issue_cnt <= 3'd0;
            ret_cnt   <= 3'd0;
         end
         if (state == ST_ISSUE) issue_cnt <= issue_cnt + 3'd1;
         if (cap_en)            ret_cnt   <= ret_cnt + 3'd1;
      end
   end

   icache_line_buffer u_line_buffer (
      .cpu_clk   (cpu_clk),
      .cpu_rst_n (cpu_rst_n),
      .wr_en     (cap_en),
      .wr_slot   (start_q + ret_cnt),
      .wr_data   (mem_rdata),
      .line      (dev_rdata)
   );

endmodule

// File: tb/tb_icache_line_fetcher.sv
// tb/tb_icache_line_fetcher.sv - directed self-checking bench for icache_line_fetcher
// Honours ICACHE_CRIT_WORD_FIRST_EN when computing the expected issue order.
module tb_icache_line_fetcher;

   logic         cpu_clk;
   logic         cpu_rst_n;
   logic         dev_rrdy;
   logic [3:0]   cpu_ren;
   logic [31:0]  cpu_raddr;
   logic         dev_rvalid;
   logic [255:0] dev_rdata;
   logic         mem_en;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_rdata;
   logic [31:0]  ram_tag;

   int checks;
   int passes;

   icache_line_fetcher dut (
      .cpu_clk    (cpu_clk),
      .cpu_rst_n  (cpu_rst_n),
      .dev_rrdy   (dev_rrdy),
      .cpu_ren    (cpu_ren),
      .cpu_raddr  (cpu_raddr),
      .dev_rvalid (dev_rvalid),
      .dev_rdata  (dev_rdata),
      .mem_en     (mem_en),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   // Instruction RAM model: one-cycle latency, word k of any line returns ram_tag + k.
   always @(posedge cpu_clk) begin
      if (mem_en) mem_rdata <= ram_tag + {29'd0, mem_addr[4:2]};
   end

   function automatic logic [2:0] crit_start(input logic [31:0] a);
`ifdef ICACHE_CRIT_WORD_FIRST_EN
      return a[4:2];
`else
      return 3'd0;
`endif
   endfunction

   function automatic logic [255:0] exp_line(input logic [31:0] tag);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[32*k +: 32] = tag + k;
      return l;
   endfunction

   task automatic check_outputs(input string name, input int cyc,
                                input logic e_rrdy, input logic e_rvalid,
                                input logic e_en, input logic [31:0] e_addr);
      checks++;
      if ({dev_rrdy, dev_rvalid, mem_en, mem_addr} !== {e_rrdy, e_rvalid, e_en, e_addr})
         $display("FAIL %s cycle %0d: rrdy/rvalid/en/addr got %b/%b/%b/%h want %b/%b/%b/%h",
                  name, cyc, dev_rrdy, dev_rvalid, mem_en, mem_addr,
                  e_rrdy, e_rvalid, e_en, e_addr);
      else passes++;
   endtask

   task automatic test_reset();
      cpu_rst_n = 1'b0;
      cpu_ren   = 4'h0;
      cpu_raddr = 32'd0;
      ram_tag   = 32'hA000_0000;
      repeat (3) @(negedge cpu_clk);
      check_outputs("reset", 0, 1'b1, 1'b0, 1'b0, 32'd0);
      checks++;
      if (dev_rdata !== 256'd0) $display("FAIL reset_rdata got %h want 0", dev_rdata);
      else passes++;
      cpu_rst_n = 1'b1;
      @(negedge cpu_clk);
   endtask

   // Request at the negedge of cycle 0, accepted at its ending edge, then checked through cycle 11.
   task automatic run_line(input string name, input logic [31:0] addr, input logic [31:0] base);
      logic [2:0]  s;
      logic [31:0] e_addr;
      s = crit_start(addr);
      ram_tag   = 32'hA000_0000;
      cpu_ren   = 4'hF;
      cpu_raddr = addr;
      @(negedge cpu_clk);
      cpu_ren = 4'h0;
      for (int cyc = 1; cyc <= 11; cyc++) begin
         if (cyc > 1) @(negedge cpu_clk);
         e_addr = (cyc <= 8) ? base + 32'(4 * ((s + cyc - 1) % 8)) : 32'd0;
         check_outputs(name, cyc, cyc == 11, cyc == 10, cyc <= 8, e_addr);
         if (cyc >= 10) begin
            checks++;
            if (dev_rdata !== exp_line(32'hA000_0000))
               $display("FAIL %s_rdata cycle %0d got %h want %h", name, cyc, dev_rdata,
                        exp_line(32'hA000_0000));
            else passes++;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e_addr;
      ram_tag   = 32'hA000_0000;
      cpu_ren   = 4'hF;
      cpu_raddr = 32'h0000_1000;
      @(negedge cpu_clk);
      for (int cyc = 1; cyc <= 21; cyc++) begin
         if (cyc > 1) @(negedge cpu_clk);
         if (cyc <= 8)
            e_addr = 32'h1000 + 32'(4 * ((crit_start(32'h1000) + cyc - 1) % 8));
         else if (cyc >= 12 && cyc <= 19)
            e_addr = 32'h2000 + 32'(4 * ((crit_start(32'h2000) + cyc - 12) % 8));
         else
            e_addr = 32'd0;
         check_outputs("b2b", cyc, cyc == 11, (cyc == 10) || (cyc == 21),
                       (cyc <= 8) || (cyc >= 12 && cyc <= 19), e_addr);
         if (cyc == 10 || cyc == 21) begin
            checks++;
            if (dev_rdata !== exp_line(cyc == 10 ? 32'hA000_0000 : 32'hB000_0000))
               $display("FAIL b2b_rdata cycle %0d got %h", cyc, dev_rdata);
            else passes++;
         end
         if (cyc == 11) ram_tag = 32'hB000_0000;
         cpu_ren   = (cyc == 3 || cyc == 10 || cyc == 11) ? 4'hF : 4'h0;
         cpu_raddr = (cyc == 11) ? 32'h0000_2000 : 32'h0000_3000;
      end
      cpu_ren = 4'h0;
      @(negedge cpu_clk);
   endtask

   task automatic test_reset_mid_line();
      cpu_ren   = 4'h5;
      cpu_raddr = 32'h0000_0400;
      @(negedge cpu_clk);
      cpu_ren = 4'h0;
      repeat (4) @(negedge cpu_clk);
      cpu_rst_n = 1'b0;
      #1;
      check_outputs("rst_mid", 5, 1'b1, 1'b0, 1'b0, 32'd0);
      checks++;
      if (dev_rdata !== 256'd0) $display("FAIL rst_mid_rdata got %h want 0", dev_rdata);
      else passes++;
      @(negedge cpu_clk);
      cpu_rst_n = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge cpu_clk);
         checks++;
         if (dev_rvalid !== 1'b0 || mem_en !== 1'b0)
            $display("FAIL rst_mid_quiet cycle %0d rvalid=%b en=%b want 0/0", cyc, dev_rvalid, mem_en);
         else passes++;
      end
      run_line("after_rst", 32'h0000_0400, 32'h0000_0400);
   endtask

   initial begin
      checks = 0;
      passes = 0;
      test_reset();
      run_line("seq_1234", 32'h0000_1234, 32'h0000_1220);
      run_line("masked", 32'hFFFF_FFE0, 32'h0000_7FE0);
      run_line("crit_58", 32'h0000_0058, 32'h0000_0040);
      test_back_to_back();
      test_reset_mid_line();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
